// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU datapath memory interface.
package cpu_pkg;

    localparam int AWIDTH = 12;
    localparam int DWIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

endpackage

// File: rtl/main_memory_responder_mem_array.sv
// Single-port RAM behind the memory responder: synchronous write and read, no reset.
module mem_array #(
    parameter int AWIDTH = cpu_pkg::AWIDTH,
    parameter int DWIDTH = cpu_pkg::DWIDTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    // Read register only moves on a read, so it holds the last read word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/main_memory_responder.sv
// Word-addressed main memory responder with programmable wait states.
// Optional build macro MEM_WRITE_PROTECT_EN blocks writes below PROT_LIMIT.
module main_memory_responder #(
    parameter int AWIDTH      = cpu_pkg::AWIDTH,
    parameter int DWIDTH      = cpu_pkg::DWIDTH,
    parameter int WAIT_STATES = 1,
    parameter int PROT_LIMIT  = 16
) (
    input  logic              clk,
    input  logic              i_clr_reg,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic [DWIDTH-1:0] o_rdata,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_err
);

    import cpu_pkg::*;

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("WAIT_STATES must lie in 0..15 (4-bit wait counter)");
        end
        if (PROT_LIMIT < 0 || PROT_LIMIT > 2**AWIDTH) begin : g_bad_prot_limit
            $error("PROT_LIMIT must lie in 0..2**AWIDTH");
        end
    endgenerate

    mem_state_t        state;
    mem_op_t           op;
    logic [3:0]        cnt;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              rdata_vld;
    logic              protect_hit;
    logic              accept;
    logic              access_now;
    logic              ram_we;
    logic              ram_re;
    logic [DWIDTH-1:0] ram_q;

`ifdef MEM_WRITE_PROTECT_EN
    assign protect_hit = (op == OP_WRITE) && (32'(addr_q) < 32'(PROT_LIMIT));
`else
    assign protect_hit = 1'b0;
`endif

    assign accept     = (state == IDLE) && (i_read ^ i_write);
    assign access_now = (state == WAIT) && (cnt == 4'd0);
    assign ram_we     = access_now && (op == OP_WRITE) && !protect_hit;
    assign ram_re     = access_now && (op == OP_READ);

    // Read data is zero until the first read after reset; the RAM itself is never cleared.
    assign o_rdata = rdata_vld ? ram_q : '0;

    always_ff @(posedge clk or posedge i_clr_reg) begin
        if (i_clr_reg) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            o_ready   <= 1'b0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
            rdata_vld <= 1'b0;
        end else begin
            o_ready <= 1'b0;
            o_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= WAIT;
                        cnt    <= 4'(WAIT_STATES);
                        o_busy <= 1'b1;
                    end else if (i_read && i_write) begin
                        o_err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state   <= DONE;
                        o_ready <= 1'b1;
                        o_err   <= protect_hit;
                        if (op == OP_READ) begin
                            rdata_vld <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Request fields are captured only at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            op      <= i_write ? OP_WRITE : OP_READ;
        end
    end

    mem_array #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: one instance with one wait state, one with none.
module tb_main_memory_responder;

    logic        clk;
    logic        clr;
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        sel;

    logic        rd1, wr1, rd0, wr0;
    logic [15:0] rdata1, rdata0, rdata;
    logic        ready1, busy1, err1, ready0, busy0, err0;
    logic        ready, busy, err;

    int tests_run    = 0;
    int tests_failed = 0;
    int cur_ws;

    logic [15:0] mdl1 [int];
    logic [15:0] mdl0 [int];

    assign rd1   = rd & ~sel;
    assign wr1   = wr & ~sel;
    assign rd0   = rd & sel;
    assign wr0   = wr & sel;
    assign rdata = sel ? rdata0 : rdata1;
    assign ready = sel ? ready0 : ready1;
    assign busy  = sel ? busy0  : busy1;
    assign err   = sel ? err0   : err1;

    main_memory_responder #(.AWIDTH(12), .DWIDTH(16), .WAIT_STATES(1), .PROT_LIMIT(16)) u_dut (
        .clk(clk), .i_clr_reg(clr), .i_read(rd1), .i_write(wr1), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rdata1), .o_ready(ready1), .o_busy(busy1), .o_err(err1)
    );

    main_memory_responder #(.AWIDTH(12), .DWIDTH(16), .WAIT_STATES(0), .PROT_LIMIT(16)) u_dut0 (
        .clk(clk), .i_clr_reg(clr), .i_read(rd0), .i_write(wr0), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rdata0), .o_ready(ready0), .o_busy(busy0), .o_err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Protected-region rule of the reference model.
    function automatic bit is_prot(input bit is_wr, input logic [11:0] a);
`ifdef MEM_WRITE_PROTECT_EN
        return is_wr && (a < 12'd16);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void mdl_write(input logic [11:0] a, input logic [15:0] d);
        if (sel) mdl0[int'(a)] = d;
        else     mdl1[int'(a)] = d;
    endfunction

    function automatic logic [15:0] mdl_read(input logic [11:0] a);
        if (sel) return mdl0[int'(a)];
        return mdl1[int'(a)];
    endfunction

    // Issues one request and reports what the DUT did; callers judge the result.
    task automatic txn(input bit is_wr, input logic [11:0] a, input logic [15:0] d,
                       output int lat, output logic [15:0] rdv, output bit err_rdy,
                       output int busy_n, output int ready_n, output bit tmo);
        lat = -1; rdv = '0; err_rdy = 1'b0; busy_n = 0; ready_n = 0; tmo = 1'b1;
        rd = !is_wr; wr = is_wr; addr = a; wdata = d;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        addr = 12'($urandom); wdata = 16'($urandom);
        for (int k = 0; k < 32; k++) begin
            if (busy) busy_n++;
            if (ready) begin
                ready_n++;
                lat     = k;
                rdv     = rdata;
                err_rdy = err;
            end
            if (!busy) begin
                tmo = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        if (!is_prot(is_wr, a) && is_wr) mdl_write(a, d);
    endtask

    task automatic test_reset;
        clr = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (ready1 !== 1'b0) begin tests_failed++; $display("FAIL rst_ready got %b want 0", ready1); end
        tests_run++; if (busy1 !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %b want 0", busy1); end
        tests_run++; if (err1 !== 1'b0) begin tests_failed++; $display("FAIL rst_err got %b want 0", err1); end
        tests_run++; if (rdata1 !== 16'h0) begin tests_failed++; $display("FAIL rst_rdata got %h want 0000", rdata1); end
        tests_run++; if (busy0 !== 1'b0 || ready0 !== 1'b0) begin tests_failed++; $display("FAIL rst_dut0 busy=%b ready=%b want 0/0", busy0, ready0); end
        #3 clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        int lat, busy_n, ready_n; logic [15:0] rdv; bit e, tmo;
        sel = 1'b0;
        txn(1'b1, 12'h100, 16'h1234, lat, rdv, e, busy_n, ready_n, tmo);
        tests_run++; if (tmo || lat !== 2) begin tests_failed++; $display("FAIL wr_latency got %0d want 2", lat); end
        tests_run++; if (busy_n !== 3) begin tests_failed++; $display("FAIL wr_busy_cycles got %0d want 3", busy_n); end
        tests_run++; if (ready_n !== 1 || e !== 1'b0) begin tests_failed++; $display("FAIL wr_ready_err got %0d/%b want 1/0", ready_n, e); end
        txn(1'b0, 12'h100, 16'h0, lat, rdv, e, busy_n, ready_n, tmo);
        tests_run++; if (tmo || lat !== 2) begin tests_failed++; $display("FAIL rd_latency got %0d want 2", lat); end
        tests_run++; if (busy_n !== 3) begin tests_failed++; $display("FAIL rd_busy_cycles got %0d want 3", busy_n); end
        tests_run++; if (rdv !== 16'h1234) begin tests_failed++; $display("FAIL rd_data got %h want 1234", rdv); end
        tests_run++; if (rdata !== 16'h1234) begin tests_failed++; $display("FAIL rd_data_hold got %h want 1234", rdata); end
    endtask

    task automatic test_zero_wait;
        int lat, busy_n, ready_n; logic [15:0] rdv; bit e, tmo;
        sel = 1'b1;
        txn(1'b1, 12'hFFF, 16'hBEEF, lat, rdv, e, busy_n, ready_n, tmo);
        tests_run++; if (tmo || lat !== 1) begin tests_failed++; $display("FAIL ws0_wr_latency got %0d want 1", lat); end
        txn(1'b0, 12'hFFF, 16'h0, lat, rdv, e, busy_n, ready_n, tmo);
        tests_run++; if (tmo || lat !== 1) begin tests_failed++; $display("FAIL ws0_rd_latency got %0d want 1", lat); end
        tests_run++; if (busy_n !== 2) begin tests_failed++; $display("FAIL ws0_busy_cycles got %0d want 2", busy_n); end
        tests_run++; if (rdv !== 16'hBEEF) begin tests_failed++; $display("FAIL ws0_rd_data got %h want beef", rdv); end
        sel = 1'b0;
    endtask

    task automatic test_both_high;
        int lat, busy_n, ready_n; logic [15:0] rdv; bit e, tmo;
        sel = 1'b0;
        txn(1'b1, 12'h200, 16'h3C3C, lat, rdv, e, busy_n, ready_n, tmo);
        rd = 1'b1; wr = 1'b1; addr = 12'h200; wdata = 16'hFFFF;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL both_err got %b want 1", err); end
        tests_run++; if (ready !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL both_idle ready=%b busy=%b want 0/0", ready, busy); end
        @(posedge clk); #1;
        tests_run++; if (err !== 1'b0 || ready !== 1'b0) begin tests_failed++; $display("FAIL both_err_pulse err=%b ready=%b want 0/0", err, ready); end
        txn(1'b0, 12'h200, 16'h0, lat, rdv, e, busy_n, ready_n, tmo);
        tests_run++; if (rdv !== mdl_read(12'h200)) begin tests_failed++; $display("FAIL both_mem_unchanged got %h want %h", rdv, mdl_read(12'h200)); end
    endtask

    task automatic test_reset_mid_write;
        int lat, busy_n, ready_n; logic [15:0] rdv; bit e, tmo;
        sel = 1'b0;
        txn(1'b1, 12'h020, 16'h5555, lat, rdv, e, busy_n, ready_n, tmo);
        wr = 1'b1; addr = 12'h020; wdata = 16'hAAAA;
        @(posedge clk); #1;
        wr = 1'b0;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        #2 clr = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0 || ready !== 1'b0 || err !== 1'b0 || rdata !== 16'h0) begin
            tests_failed++;
            $display("FAIL midrst_outputs busy=%b ready=%b err=%b rdata=%h want 0/0/0/0000", busy, ready, err, rdata);
        end
        #1 clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b0 || ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_stays_idle busy=%b ready=%b want 0/0", busy, ready); end
        txn(1'b0, 12'h020, 16'h0, lat, rdv, e, busy_n, ready_n, tmo);
        tests_run++; if (rdv !== 16'h5555) begin tests_failed++; $display("FAIL midrst_old_data got %h want 5555", rdv); end
    endtask

    task automatic test_hold_read;
        int lat, busy_n, ready_n; logic [15:0] rdv; bit e, tmo, seen;
        sel = 1'b0;
        txn(1'b1, 12'h300, 16'h1111, lat, rdv, e, busy_n, ready_n, tmo);
        txn(1'b1, 12'h301, 16'h2222, lat, rdv, e, busy_n, ready_n, tmo);
        rd = 1'b1; addr = 12'h300;
        @(posedge clk); #1;
        addr = 12'h301;
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (ready) begin
                seen = 1'b1;
                tests_run++; if (k !== 2) begin tests_failed++; $display("FAIL hold_latency got %0d want 2", k); end
                tests_run++; if (rdata !== 16'h1111) begin tests_failed++; $display("FAIL hold_latched_addr got %h want 1111", rdata); end
                break;
            end
            @(posedge clk); #1;
        end
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL hold_first_ready got timeout want pulse"); end
        @(posedge clk); #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL hold_idle_gap got busy=%b want 0", busy); end
        @(posedge clk); #1;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL hold_second_accept got busy=%b want 1", busy); end
        rd = 1'b0; addr = 12'h300;
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (ready) begin
                seen = 1'b1;
                tests_run++; if (rdata !== 16'h2222) begin tests_failed++; $display("FAIL hold_second_data got %h want 2222", rdata); end
                break;
            end
            @(posedge clk); #1;
        end
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL hold_second_ready got timeout want pulse"); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_protect;
        int lat, busy_n, ready_n; logic [15:0] rdv, old; bit e, tmo;
        sel = 1'b0;
`ifdef MEM_WRITE_PROTECT_EN
        txn(1'b0, 12'h00F, 16'h0, lat, rdv, e, busy_n, ready_n, tmo);
        old = rdv;
        txn(1'b1, 12'h00F, 16'h7777, lat, rdv, e, busy_n, ready_n, tmo);
        tests_run++; if (tmo || lat !== 2) begin tests_failed++; $display("FAIL prot_latency got %0d want 2", lat); end
        tests_run++; if (e !== 1'b1 || ready_n !== 1) begin tests_failed++; $display("FAIL prot_err_with_ready got err=%b readys=%0d want 1/1", e, ready_n); end
        txn(1'b0, 12'h00F, 16'h0, lat, rdv, e, busy_n, ready_n, tmo);
        tests_run++; if (rdv !== old) begin tests_failed++; $display("FAIL prot_not_written got %h want %h", rdv, old); end
`else
        txn(1'b1, 12'h00F, 16'h7777, lat, rdv, e, busy_n, ready_n, tmo);
        tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL low_wr_err got %b want 0", e); end
        txn(1'b0, 12'h00F, 16'h0, lat, rdv, e, busy_n, ready_n, tmo);
        tests_run++; if (rdv !== 16'h7777) begin tests_failed++; $display("FAIL low_wr_data got %h want 7777", rdv); end
`endif
        txn(1'b1, 12'h010, 16'h0ABC, lat, rdv, e, busy_n, ready_n, tmo);
        tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL edge_wr_err got %b want 0", e); end
        txn(1'b0, 12'h010, 16'h0, lat, rdv, e, busy_n, ready_n, tmo);
        tests_run++; if (rdv !== 16'h0ABC) begin tests_failed++; $display("FAIL edge_wr_data got %h want 0abc", rdv); end
    endtask

    task automatic test_random;
        int lat, busy_n, ready_n; logic [15:0] rdv, d; bit e, tmo, is_wr;
        logic [11:0] pool [8];
        logic [11:0] a;
        sel = 1'b0;
        cur_ws = 1;
        for (int i = 0; i < 8; i++) begin
            pool[i] = 12'($urandom_range(12'h400 + i * 12'h100, 12'h4FF + i * 12'h100));
            d = 16'($urandom);
            txn(1'b1, pool[i], d, lat, rdv, e, busy_n, ready_n, tmo);
        end
        for (int n = 0; n < 40; n++) begin
            is_wr = 1'($urandom);
            a     = pool[$urandom_range(0, 7)];
            if (is_wr && ($urandom_range(0, 3) == 0)) a = 12'($urandom_range(0, 31));
            d = 16'($urandom);
            txn(is_wr, a, d, lat, rdv, e, busy_n, ready_n, tmo);
            tests_run++;
            if (tmo || lat !== cur_ws + 1 || ready_n !== 1 || busy_n !== cur_ws + 2) begin
                tests_failed++;
                $display("FAIL rand_timing n=%0d lat=%0d readys=%0d busy=%0d want %0d/1/%0d", n, lat, ready_n, busy_n, cur_ws + 1, cur_ws + 2);
            end
            tests_run++;
            if (e !== is_prot(is_wr, a)) begin
                tests_failed++;
                $display("FAIL rand_err n=%0d addr=%h got %b want %b", n, a, e, is_prot(is_wr, a));
            end
            if (!is_wr) begin
                tests_run++;
                if (rdv !== mdl_read(a)) begin
                    tests_failed++;
                    $display("FAIL rand_rdata n=%0d addr=%h got %h want %h", n, a, rdv, mdl_read(a));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_both_high();
        test_reset_mid_write();
        test_hold_read();
        test_protect();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
